// File: rtl/servo_pwm_driver.sv
// Servo PWM driver: turns 4-bit angle commands into a bounded position and a
// hobby-servo PWM frame whose pulse width is MIN_PULSE + position.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_Angle_Cmd    command code: 1 = move negative, 2 = move positive, else hold
//   o_Servo_PWM    registered servo pulse
//   o_Pos          current position, 0..POS_MAX
//   o_At_Min       position is 0
//   o_At_Max       position is POS_MAX
//   o_Period_Start one-clock strobe on the first clock of each PWM frame
module servo_pwm_driver #(
    parameter int unsigned CLKS_PER_PERIOD = 500000,
    parameter int unsigned MIN_PULSE       = 25000,
    parameter int unsigned POS_MAX         = 25000,
    parameter int unsigned STEP_DIV        = 250,
    parameter int unsigned INIT_POS        = 12500
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [3:0]  i_Angle_Cmd,
    output logic        o_Servo_PWM,
    output logic [15:0] o_Pos,
    output logic        o_At_Min,
    output logic        o_At_Max,
    output logic        o_Period_Start
);

    localparam int unsigned CNT_W  = (CLKS_PER_PERIOD > 1) ? $clog2(CLKS_PER_PERIOD) : 1;
    localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned POS_W  = 16;
    localparam int unsigned PW_W   = 17;
    localparam int unsigned CMP_W  = (CNT_W > PW_W) ? CNT_W : PW_W;

    localparam logic [CNT_W-1:0]  PERIOD_LAST  = CNT_W'(CLKS_PER_PERIOD - 1);
    localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0]  POS_MAX_V    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]  POS_INIT_V   = POS_W'(INIT_POS);
    localparam logic [PW_W-1:0]   MIN_PULSE_V  = PW_W'(MIN_PULSE);
    localparam logic [PW_W-1:0]   WIDTH_INIT_V = PW_W'(MIN_PULSE + INIT_POS);

    localparam logic [3:0] CMD_NEG = 4'd1;
    localparam logic [3:0] CMD_POS = 4'd2;

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_MOVE_NEG = 2'd1,
        S_MOVE_POS = 2'd2
    } state_t;

    logic [3:0]        cmd_q;
    state_t            state_q;
    state_t            state_d;
    logic [STEP_W-1:0] step_cnt_q;
    logic [STEP_W-1:0] step_cnt_d;
    logic [POS_W-1:0]  pos_q;
    logic [POS_W-1:0]  pos_d;
    logic              at_min_q;
    logic              at_max_q;

    logic [CNT_W-1:0]  period_cnt_q;
    logic [PW_W-1:0]   width_q;
    logic              pwm_q;
    logic              period_start_q;

    logic [PW_W-1:0]   width_sample_c;
    logic [PW_W-1:0]   width_sel_c;
    logic              frame_first_c;
    logic              pwm_d_c;

    // Command input register: one clock of input latency.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cmd_q <= 4'd0;
        end else begin
            cmd_q <= i_Angle_Cmd;
        end
    end

    // Motion state, step divider and position registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= S_HOLD;
            step_cnt_q <= '0;
            pos_q      <= POS_INIT_V;
            at_min_q   <= (INIT_POS == 0);
            at_max_q   <= (INIT_POS == POS_MAX);
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            at_min_q   <= (pos_d == '0);
            at_max_q   <= (pos_d == POS_MAX_V);
        end
    end

    // Next-state, step divider and saturating position update.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = '0;
        pos_d      = pos_q;

        case (state_q)
            S_HOLD: begin
                if (cmd_q == CMD_NEG) begin
                    state_d = S_MOVE_NEG;
                end else if (cmd_q == CMD_POS) begin
                    state_d = S_MOVE_POS;
                end
            end
            S_MOVE_NEG: begin
                if (cmd_q == CMD_POS) begin
                    state_d = S_MOVE_POS;
                end else if (cmd_q != CMD_NEG) begin
                    state_d = S_HOLD;
                end
            end
            S_MOVE_POS: begin
                if (cmd_q == CMD_NEG) begin
                    state_d = S_MOVE_NEG;
                end else if (cmd_q != CMD_POS) begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        // Divider only runs while staying in a move state; any transition restarts it.
        if ((state_q != S_HOLD) && (state_d == state_q)) begin
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                // Steps at a bound are dropped rather than wrapping.
                if ((state_q == S_MOVE_NEG) && (pos_q != '0)) begin
                    pos_d = pos_q - POS_W'(1);
                end else if ((state_q == S_MOVE_POS) && (pos_q < POS_MAX_V)) begin
                    pos_d = pos_q + POS_W'(1);
                end
            end else begin
                step_cnt_d = step_cnt_q + STEP_W'(1);
            end
        end
    end

    // Pulse width for the frame: sampled from the pre-step position at counter 0.
    always_comb begin
        width_sample_c = MIN_PULSE_V + PW_W'(pos_q);
        frame_first_c  = (period_cnt_q == '0);
        width_sel_c    = frame_first_c ? width_sample_c : width_q;
        pwm_d_c        = (CMP_W'(period_cnt_q) < CMP_W'(width_sel_c));
    end

    // Free-running frame counter, width shadow and registered pulse/strobe.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            period_cnt_q   <= '0;
            width_q        <= WIDTH_INIT_V;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            if (period_cnt_q == PERIOD_LAST) begin
                period_cnt_q <= '0;
            end else begin
                period_cnt_q <= period_cnt_q + CNT_W'(1);
            end
            if (frame_first_c) begin
                width_q <= width_sample_c;
            end
            pwm_q          <= pwm_d_c;
            period_start_q <= frame_first_c;
        end
    end

    assign o_Servo_PWM    = pwm_q;
    assign o_Pos          = pos_q;
    assign o_At_Min       = at_min_q;
    assign o_At_Max       = at_max_q;
    assign o_Period_Start = period_start_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver with small sim parameters; frame pulse
// widths are queued as expectations and popped when a frame is measured.
module tb_servo_pwm_driver;

    localparam int unsigned P_PERIOD = 100;
    localparam int unsigned P_MINP   = 10;
    localparam int unsigned P_PMAX   = 20;
    localparam int unsigned P_STEP   = 4;
    localparam int unsigned P_INIT   = 10;

    logic        i_Clk;
    logic        i_Rst_L;
    logic [3:0]  i_Angle_Cmd;
    logic        o_Servo_PWM;
    logic [15:0] o_Pos;
    logic        o_At_Min;
    logic        o_At_Max;
    logic        o_Period_Start;

    servo_pwm_driver #(
        .CLKS_PER_PERIOD(P_PERIOD),
        .MIN_PULSE      (P_MINP),
        .POS_MAX        (P_PMAX),
        .STEP_DIV       (P_STEP),
        .INIT_POS       (P_INIT)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_Angle_Cmd   (i_Angle_Cmd),
        .o_Servo_PWM   (o_Servo_PWM),
        .o_Pos         (o_Pos),
        .o_At_Min      (o_At_Min),
        .o_At_Max      (o_At_Max),
        .o_Period_Start(o_Period_Start)
    );

    typedef struct {
        string tag;
        int    width;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;
    int   n_fail;

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input string tag, input int width);
        exp_t e;
        e.tag   = tag;
        e.width = width;
        sb.push_back(e);
    endtask

    task automatic wait_start(input string tag, output bit found);
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (o_Period_Start) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check({tag, "_start_seen"}, int'(found), 1);
    endtask

    // Measures one full frame from its start strobe; optionally drives a
    // command pulse at given frame offsets while the frame is in progress.
    task automatic measure_frame(input int cmd_at, input int cmd_end, input logic [3:0] cmd_val);
        exp_t e;
        bit   found;
        int   highs;
        int   starts;
        e = sb.pop_front();
        wait_start(e.tag, found);
        if (!found) return;
        highs  = 0;
        starts = 0;
        for (int i = 0; i < int'(P_PERIOD); i++) begin
            if (i == cmd_at)  i_Angle_Cmd = cmd_val;
            if (i == cmd_end) i_Angle_Cmd = 4'd0;
            if (o_Servo_PWM)    highs++;
            if (o_Period_Start) starts++;
            tick(1);
        end
        check({e.tag, "_width"}, highs, e.width);
        check({e.tag, "_starts"}, starts, 1);
    endtask

    initial begin
        bit found;
        n_checks    = 0;
        n_pass      = 0;
        n_fail      = 0;
        i_Rst_L     = 1'b0;
        i_Angle_Cmd = 4'd0;

        // Reset state
        tick(3);
        check("rst_pwm",   int'(o_Servo_PWM), 0);
        check("rst_start", int'(o_Period_Start), 0);
        check("rst_pos",   int'(o_Pos), 10);
        check("rst_atmin", int'(o_At_Min), 0);
        check("rst_atmax", int'(o_At_Max), 0);

        // First frame begins on the first clock after release
        i_Rst_L = 1'b1;
        tick(1);
        check("first_start", int'(o_Period_Start), 1);
        check("first_pwm",   int'(o_Servo_PWM), 1);
        expect_frame("idle_f0", 20);
        expect_frame("idle_f1", 20);
        expect_frame("idle_f2", 20);
        repeat (3) measure_frame(-1, -1, 4'd0);
        check("idle_pos", int'(o_Pos), 10);

        // Short positive move: first step 4 clocks after entering MOVE_POS
        i_Angle_Cmd = 4'd2;
        tick(5);
        check("step_before", int'(o_Pos), 10);
        tick(1);
        check("step_first", int'(o_Pos), 11);
        tick(10);
        i_Angle_Cmd = 4'd0;
        tick(5);
        check("short_move_pos", int'(o_Pos), 13);
        expect_frame("pos13", 23);
        measure_frame(-1, -1, 4'd0);

        // Saturate at POS_MAX
        i_Angle_Cmd = 4'd2;
        tick(200);
        check("sat_max_pos",   int'(o_Pos), 20);
        check("sat_max_atmax", int'(o_At_Max), 1);
        check("sat_max_atmin", int'(o_At_Min), 0);
        expect_frame("pos20", 30);
        measure_frame(-1, -1, 4'd0);
        i_Angle_Cmd = 4'd0;

        // Position moves during the pulse; width changes only next frame
        expect_frame("midframe_cur", 30);
        measure_frame(4, 24, 4'd1);
        check("midframe_pos", int'(o_Pos), 16);
        expect_frame("midframe_next", 26);
        measure_frame(-1, -1, 4'd0);

        // Non-move codes hold position
        i_Angle_Cmd = 4'd0;  tick(100); check("hold_c0",  int'(o_Pos), 16);
        i_Angle_Cmd = 4'd5;  tick(100); check("hold_c5",  int'(o_Pos), 16);
        i_Angle_Cmd = 4'd7;  tick(100); check("hold_c7",  int'(o_Pos), 16);
        i_Angle_Cmd = 4'd15; tick(100); check("hold_c15", int'(o_Pos), 16);
        check("hold_atmin", int'(o_At_Min), 0);
        check("hold_atmax", int'(o_At_Max), 0);

        // Saturate at 0
        i_Angle_Cmd = 4'd1;
        tick(200);
        check("sat_min_pos",   int'(o_Pos), 0);
        check("sat_min_atmin", int'(o_At_Min), 1);
        check("sat_min_atmax", int'(o_At_Max), 0);
        expect_frame("pos0", 10);
        measure_frame(-1, -1, 4'd0);

        // Direct 1->2 switch restarts the step divider
        i_Angle_Cmd = 4'd0;
        tick(10);
        i_Angle_Cmd = 4'd1;
        tick(6);
        i_Angle_Cmd = 4'd2;
        tick(5);
        check("toggle_before", int'(o_Pos), 0);
        tick(1);
        check("toggle_step", int'(o_Pos), 1);
        i_Angle_Cmd = 4'd0;
        tick(10);
        check("toggle_final", int'(o_Pos), 1);
        check("toggle_atmin", int'(o_At_Min), 0);

        // Ramp to 17, then reset in the middle of a pulse
        i_Angle_Cmd = 4'd2;
        tick(66);
        i_Angle_Cmd = 4'd0;
        tick(10);
        check("ramp_pos", int'(o_Pos), 17);
        wait_start("prereset", found);
        tick(7);
        check("prereset_pwm", int'(o_Servo_PWM), 1);
        i_Rst_L = 1'b0;
        #1;
        check("rst_mid_pwm",   int'(o_Servo_PWM), 0);
        check("rst_mid_pos",   int'(o_Pos), 10);
        check("rst_mid_start", int'(o_Period_Start), 0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        tick(1);
        check("post_rst_start", int'(o_Period_Start), 1);
        check("post_rst_pwm",   int'(o_Servo_PWM), 1);
        expect_frame("post_rst", 20);
        measure_frame(-1, -1, 4'd0);
        check("post_rst_pos", int'(o_Pos), 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
- Consumer end of the 4-bit angle command interface produced by the switch/auto angle logic.
- Turns command codes into a bounded servo position and a standard hobby-servo PWM waveform.
- One instance per axis (x, y, fire); sits between the angle-command FSMs and the servo output pins.

Parameters:
- CLKS_PER_PERIOD, 500000: PWM frame length in clocks (20 ms at 25 MHz).
- MIN_PULSE, 25000: pulse width in clocks at position 0 (1 ms).
- POS_MAX, 25000: maximum position. Pulse width at POS_MAX is MIN_PULSE+POS_MAX (2 ms).
- STEP_DIV, 250: clocks per one-unit position step while moving.
- INIT_POS, 12500: position after reset (centre). Must be ≤ POS_MAX.

Ports:
- i_Clk, input, 1: system clock.
- i_Rst_L, input, 1: asynchronous active-low reset.
- i_Angle_Cmd, input, 4: command code. 1 = move negative (left/up), 2 = move positive (right/down), any other value (0, 5, …) = hold.
- o_Servo_PWM, output, 1: servo pulse, registered.
- o_Pos, output, 16: current position, 0..POS_MAX.
- o_At_Min, output, 1: high when o_Pos == 0.
- o_At_Max, output, 1: high when o_Pos == POS_MAX.
- o_Period_Start, output, 1: one-clock strobe on the first clock of each PWM frame.

Behaviour:
- Reset (async, i_Rst_L=0):
  - o_Servo_PWM=0, o_Period_Start=0.
  - pos=INIT_POS, so o_At_Min and o_At_Max reflect INIT_POS.
  - Period counter=0, step counter=0.
  - FSM=HOLD, width shadow=MIN_PULSE+INIT_POS.
- Command input:
  - i_Angle_Cmd is registered once (cmd_q), giving 1 clock of input latency.
  - Codes other than 1 and 2 are never errors; they mean hold.
- Motion FSM (3 states), evaluated on cmd_q each clock:
  - HOLD: cmd_q==1 -> MOVE_NEG; cmd_q==2 -> MOVE_POS; else stay.
  - MOVE_NEG: cmd_q==1 stay; cmd_q==2 -> MOVE_POS; else -> HOLD.
  - MOVE_POS: symmetric to MOVE_NEG.
- Step counter:
  - Cleared on every state change and while in HOLD.
  - In MOVE_*, counts 0..STEP_DIV-1 and wraps.
  - On the clock where it equals STEP_DIV-1, pos changes by ∓1/±1 for that direction.
  - First step therefore lands STEP_DIV clocks after entering the MOVE state.
- Saturation:
  - pos never goes below 0 or above POS_MAX.
  - A step at a bound is dropped; the FSM stays in MOVE_* and the counter keeps wrapping.
  - No wrap-around of pos under any stimulus.
- o_Pos, o_At_Min, o_At_Max are registered from pos, with zero extra delay beyond the pos register.
- PWM frame:
  - Period counter runs 0..CLKS_PER_PERIOD-1 and wraps; it is free-running and independent of commands.
  - When the counter is 0: width shadow <= MIN_PULSE+pos, and o_Period_Start=1 that clock.
  - o_Servo_PWM is high for exactly width-shadow clocks starting at the clock after counter==0 (one registered cycle of lag), then low for the rest of the frame.
  - Position changes mid-frame never alter the current pulse; they take effect at the next frame boundary (glitch-free).
- Simultaneous events:
  - A step on the same clock as counter==0 is not visible in that frame's sampled width; the shadow takes the pre-step pos.
- Reset mid-pulse:
  - Output drops immediately (async).
  - First frame after release starts at counter 0 with width MIN_PULSE+INIT_POS.
- Widths:
  - Period counter is ceil(log2(CLKS_PER_PERIOD)) bits (19 at default).
  - Pulse compare is 17 bits, so MIN_PULSE+POS_MAX must not overflow it.

Test Plan (sim parameters CLKS_PER_PERIOD=100, MIN_PULSE=10, POS_MAX=20, STEP_DIV=4, INIT_POS=10):
- Reset release, cmd=0 for 300 clocks -> o_Pos=10; o_Servo_PWM high exactly 20 clocks per 100-clock frame; o_Period_Start one pulse per frame; o_At_Min=o_At_Max=0.
- cmd=2 for 16 clocks then 0 -> o_Pos goes 10 to 13 (first step 4 clocks after MOVE_POS entry, then every 4). Next frame pulse = 23 clocks.
- cmd=2 held 200 clocks -> o_Pos saturates at 20, o_At_Max=1, no overflow. Pulse = 30 clocks. Then cmd=1 held 200 clocks -> o_Pos=0, o_At_Min=1, pulse = 10 clocks.
- cmd=1 asserted at frame clock 5, position changes during the pulse -> current frame pulse width unchanged; new width appears only in the following frame.
- cmd cycling through 0, 5, 7, 15 for 100 clocks each -> o_Pos constant, FSM stays in HOLD. cmd toggling 1→2 directly -> step counter restarts and the next step occurs 4 clocks after the switch.
- i_Rst_L pulsed low for 1 clock at frame clock 8 with o_Pos=17 -> o_Servo_PWM=0 immediately; after release o_Pos=10 and the first frame pulse is 20 clocks.
